// File: rtl/wall_column_renderer_pkg.sv
// Shared constants, types and helpers for the wall column renderer.
// Holds the screen geometry, colour table, column entry layout and swap FSM states.
// Pure declarations; carries no timing or flow-control behaviour.
package render_pkg;

   localparam int H_VIS    = 640;
   localparam int V_VIS    = 480;
   localparam int V_CENTRE = 240;
   localparam int NCOL     = 160;
   localparam int HMAX     = 480;

   localparam logic [11:0] BLANK_RGB = 12'h000;
   localparam logic [11:0] CEIL_RGB  = 12'h333;
   localparam logic [11:0] FLOOR_RGB = 12'h642;

   typedef struct packed {
      logic [8:0] height;
      logic [1:0] shade;
   } col_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_SWAP    = 2'd2
   } swap_state_t;

   // Four-step grey ramp, brightest first.
   function automatic logic [11:0] shade_rgb(input logic [1:0] shade);
      logic [11:0] c;
      case (shade)
         2'd0:    c = 12'hCCC;
         2'd1:    c = 12'h999;
         2'd2:    c = 12'h666;
         default: c = 12'h444;
      endcase
      return c;
   endfunction

   // Heights above the screen height would overflow the band maths.
   function automatic logic [8:0] clamp_height(input logic [8:0] h);
      return (h > 9'(HMAX)) ? 9'(HMAX) : h;
   endfunction

endpackage

// File: rtl/wall_column_renderer_if.sv
// Column-write and swap-handshake bundle between the raycaster and the renderer.
// Combinational wires only; no latency of its own.
// wr_ready is the only backpressure: writes stall while a swap is outstanding.
interface wall_column_renderer_if;
   import render_pkg::*;

   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_col;
   logic [8:0] wr_height;
   logic [1:0] wr_shade;
   logic       wr_commit;
   logic       swap_ack;

   // Upstream raycaster side.
   modport master (
      output wr_valid, wr_col, wr_height, wr_shade, wr_commit,
      input  wr_ready, swap_ack
   );

   // Renderer side.
   modport slave (
      input  wr_valid, wr_col, wr_height, wr_shade, wr_commit,
      output wr_ready, swap_ack
   );

endinterface

// File: rtl/wall_column_renderer_column_bank.sv
// Two-bank column store: one write port, one combinational read port.
// Write lands on the next clk edge; read is zero-latency from the register array.
// No backpressure; out-of-range write addresses are silently dropped.
module column_bank
   import render_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic       wr_bank,
   input  logic [7:0] wr_addr,
   input  col_entry_t wr_data,
   input  logic       rd_bank,
   input  logic [7:0] rd_addr,
   output col_entry_t rd_data
);

   col_entry_t mem [2][NCOL];

   // Store update: clear everything on reset, otherwise accept in-range writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < NCOL; c++) begin
               mem[b][c] <= '0;
            end
         end
      end else if (wr_en && (wr_addr < 8'(NCOL))) begin
         mem[wr_bank][wr_addr] <= wr_data;
      end
   end

   // Read port: columns past the last slot (horizontal blanking) read as empty.
   always_comb begin
      rd_data = '0;
      if (rd_addr < 8'(NCOL)) begin
         rd_data = mem[rd_bank][rd_addr];
      end
   end

endmodule

// File: rtl/wall_column_renderer.sv
// Pixel colour stage: ceiling / shaded wall slice / floor from a double-buffered column store.
// rgb is registered on p_tick, one clk after the pixel is presented; swap_ack pulses one clk.
// wr_ready drops from an accepted commit until the swap completes at the next vblank start.
module wall_column_renderer
   import render_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  p_tick,
   input  logic                  video_on,
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   wall_column_renderer_if.slave wr,
   output logic [11:0]           rgb
);

   swap_state_t state, state_nxt;
   logic        front_sel;
   logic        ready_int;
   logic        ack_int;
   logic        vblank_start;
   logic        wr_fire;
   col_entry_t  wr_entry;
   col_entry_t  rd_entry;
   logic [9:0]  half_h;
   logic [9:0]  band_top;
   logic [9:0]  band_bot;
   logic [11:0] pix_rgb;

   assign vblank_start = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'(V_VIS));
   assign wr_fire      = wr.wr_valid && ready_int;
   assign wr_entry     = '{height: clamp_height(wr.wr_height), shade: wr.wr_shade};

   assign wr.wr_ready  = ready_int;
   assign wr.swap_ack  = ack_int;

   column_bank u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_fire),
      .wr_bank (~front_sel),
      .wr_addr (wr.wr_col),
      .wr_data (wr_entry),
      .rd_bank (front_sel),
      .rd_addr (pixel_x[9:2]),
      .rd_data (rd_entry)
   );

   // Swap FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Swap FSM next state and handshake outputs; commits while pending are ignored.
   always_comb begin
      state_nxt = state;
      ready_int = 1'b0;
      ack_int   = 1'b0;
      case (state)
         ST_IDLE: begin
            ready_int = 1'b1;
            if (wr.wr_commit) state_nxt = ST_PENDING;
         end
         ST_PENDING: begin
            if (vblank_start) state_nxt = ST_SWAP;
         end
         ST_SWAP: begin
            ack_int   = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Display bank select flips only in the SWAP clk, which follows vblank start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         front_sel <= 1'b0;
      end else if (state == ST_SWAP) begin
         front_sel <= ~front_sel;
      end
   end

   // Wall band is symmetric about the screen centre; odd heights round down.
   always_comb begin
      half_h   = {1'b0, rd_entry.height} >> 1;
      band_top = 10'(V_CENTRE) - half_h;
      band_bot = 10'(V_CENTRE) + half_h;
      pix_rgb  = BLANK_RGB;
      if (video_on) begin
         if (pixel_y < band_top) begin
            pix_rgb = CEIL_RGB;
         end else if (pixel_y < band_bot) begin
            pix_rgb = shade_rgb(rd_entry.shade);
         end else begin
            pix_rgb = FLOOR_RGB;
         end
      end
   end

   // Output pixel register, loaded once per pixel tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb <= BLANK_RGB;
      end else if (p_tick) begin
         rgb <= pix_rgb;
      end
   end

endmodule
